// File: rtl/aes_io_sequencer.sv
// Sequences one AES block at a time: receive plaintext, run the cipher core,
// transmit the ciphertext, with a cipher-timeout watchdog and a sticky error flag.
module aes_io_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Enable,
  output logic               ReadEn,
  input  logic               ReadRy,
  input  logic [127:0]       PT,
  output logic [127:0]       CoreIn,
  output logic               CoreStart,
  input  logic               CoreDone,
  input  logic [127:0]       CoreOut,
  output logic [127:0]       Result,
  output logic               WriteEn,
  input  logic               WriteRy,
  output logic               Busy,
  output logic               Error,
  output logic [CNT_W-1:0]   BlockCount
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, RECV, LAUNCH, WAIT_CORE, SEND, GAP, ERROR
  } state_t;

  state_t state, nextState;
  logic [TW-1:0] timer;

  always_comb begin
    nextState = state;
    case (state)
      IDLE:      if (Enable) nextState = RECV;
      RECV:      if (ReadRy) nextState = LAUNCH;
                 else if (!Enable) nextState = IDLE;
      LAUNCH:    nextState = WAIT_CORE;
      // CoreDone on the terminal count still completes the block
      WAIT_CORE: if (CoreDone) nextState = SEND;
                 else if (timer == TLAST) nextState = ERROR;
      SEND:      if (WriteRy) nextState = GAP;
      GAP:       nextState = Enable ? RECV : IDLE;
      ERROR:     if (!Enable) nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they align with the state itself
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state      <= IDLE;
      ReadEn     <= 1'b0;
      CoreStart  <= 1'b0;
      WriteEn    <= 1'b0;
      Busy       <= 1'b0;
      Error      <= 1'b0;
      BlockCount <= '0;
      CoreIn     <= '0;
      Result     <= '0;
      timer      <= '0;
    end else begin
      state     <= nextState;
      ReadEn    <= (nextState == RECV);
      CoreStart <= (nextState == LAUNCH);
      WriteEn   <= (nextState == SEND);
      Busy      <= !((nextState == IDLE) || (nextState == ERROR));
      if (nextState == ERROR) Error <= 1'b1;

      if (state == LAUNCH) timer <= '0;
      else if (state == WAIT_CORE) timer <= timer + 1'b1;

      if ((state == RECV) && ReadRy) CoreIn <= PT;
      if ((state == WAIT_CORE) && CoreDone) Result <= CoreOut;
      if ((state == SEND) && WriteRy) BlockCount <= BlockCount + 1'b1;
    end
  end

endmodule
